shift_left_iter: RTL and testbench



---
 rtl/shift_left_iter_if.sv | 24 ++
 rtl/shift_left_iter.sv | 114 +++++++++++
 tb/tb_shift_left_iter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_left_iter_if.sv
// Valid/ready operand and result channels of the iterative left shifter.
interface shift_left_iter_if #(
  parameter int BITS  = 5,
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [BITS-1:0]  in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/shift_left_iter.sv
// Multi-cycle logical left shifter, one log stage per clock, with signed-overflow flag.
// Optional macro SHL_EARLY_EXIT_EN: finish as soon as no higher amount bits remain.
module shift_left_iter #(
  parameter int BITS  = 5,
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  shift_left_iter_if.slave  bus
);

  if (WIDTH != (1 << BITS)) begin : g_bad_width
    $error("shift_left_iter: WIDTH must equal 2**BITS");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [BITS-1:0]  amt_q, amt_d;
  logic [BITS-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, in_ready_q;

  int unsigned      k;
  logic [WIDTH-1:0] top, ones;
  logic             last;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    amt_d      = amt_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    // The k+1 bits that will be pushed past (or onto) the sign bit by this stage.
    k    = 1 << cnt_q;
    top  = acc_q >> (WIDTH - 1 - k);
    ones = (WIDTH'(1) << (k + 1)) - WIDTH'(1);

`ifdef SHL_EARLY_EXIT_EN
    last = (cnt_q == BITS'(BITS - 1)) || ((amt_q >> (cnt_q + 1'b1)) == '0);
`else
    last = (cnt_q == BITS'(BITS - 1));
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          amt_d   = bus.in_amt;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
`ifdef SHL_EARLY_EXIT_EN
          if (bus.in_amt == '0) state_d = DONE;
`endif
        end
      end
      SHIFT: begin
        if (amt_q[cnt_q]) begin
          acc_d = acc_q << k;
          ovf_d = ovf_q | ((top != '0) && (top != ones));
        end
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result registers load only on entry to DONE so they stay frozen under backpressure.
    if (state_d == DONE && state_q != DONE) begin
      out_data_d = acc_d;
      out_ovf_d  = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      amt_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      amt_q       <= amt_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_shift_left_iter.sv
// Scoreboarded random/directed bench for shift_left_iter against an arithmetic reference.
module tb_shift_left_iter;
  localparam int BITS  = 5;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             o;
    int               lat;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rand_bp = 1'b0;
  bit   held = 1'b0;
  exp_t q[$];

  shift_left_iter_if #(.BITS(BITS), .WIDTH(WIDTH)) bus ();

  shift_left_iter #(.BITS(BITS), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] ref_d(logic [WIDTH-1:0] d, int a);
    return d << a;
  endfunction

  // Overflow iff the top a+1 bits are not a pure sign extension.
  function automatic logic ref_o(logic [WIDTH-1:0] d, int a);
    logic signed [WIDTH-1:0] s;
    s = $signed(d) >>> (WIDTH - 1 - a);
    return !((s == 0) || (s == -1));
  endfunction

  function automatic int ref_lat(int a);
`ifdef SHL_EARLY_EXIT_EN
    int hb;
    if (a == 0) return 1;
    hb = 0;
    for (int i = 0; i < BITS; i++) if (((a >> i) & 1) == 1) hb = i;
    return hb + 2;
`else
    return BITS + 1;
`endif
  endfunction

  function automatic void chk(string nm, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: check each result once, on the first cycle it is presented.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (bus.out_valid && !held) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_result: got out_valid with data %h, want none", bus.out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_ovf", WIDTH'(bus.out_ovf), WIDTH'(e.o));
          chk("latency", WIDTH'(cyc - e.acc + 1), WIDTH'(e.lat));
        end
      end
      held = bus.out_valid;
    end
  end

  always @(negedge clk) if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);

  task automatic issue(input logic [WIDTH-1:0] d, input int a);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = BITS'(a);
    @(posedge clk);
    #1;
    e.d   = ref_d(d, a);
    e.o   = ref_o(d, a);
    e.lat = ref_lat(a);
    e.acc = cyc;
    q.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  logic [WIDTH-1:0] dir_d [8] = '{32'h0000_00F1, 32'h0000_0003, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                                  32'h4000_0000, 32'h1234_5678, 32'h0000_0001, 32'hC000_0001};
  int               dir_a [8] = '{4, 31, 31, 0, 1, 2, 16, 1};

  initial begin
    logic [WIDTH-1:0] bp_d;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", WIDTH'(bus.in_ready), 1);
    chk("rst_out_valid", WIDTH'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ovf", WIDTH'(bus.out_ovf), 0);

    for (int i = 0; i < 8; i++) issue(dir_d[i], dir_a[i]);
    drain();

    // Backpressure: result frozen, no accept while held.
    bus.out_ready = 1'b0;
    bp_d = 32'h8123_4567;
    issue(bp_d, 8);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", WIDTH'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", WIDTH'(bus.out_valid), 1);
      chk("bp_hold_data", bus.out_data, ref_d(bp_d, 8));
      chk("bp_hold_ovf", WIDTH'(bus.out_ovf), WIDTH'(ref_o(bp_d, 8)));
      chk("bp_in_ready", WIDTH'(bus.in_ready), 0);
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0BAD_F00D;
        bus.in_amt   = 5'd3;
      end
      if (i == 5) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", WIDTH'(bus.in_ready), 1);
    chk("bp_release_valid", WIDTH'(bus.out_valid), 0);
    repeat (10) @(negedge clk);

    // Reset in the middle of an operation discards it.
    issue(32'h0000_00FF, 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_in_ready", WIDTH'(bus.in_ready), 1);
    chk("midrst_out_valid", WIDTH'(bus.out_valid), 0);
    chk("midrst_out_data", bus.out_data, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Random operands with random consumer stalls.
    rand_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = WIDTH'($urandom_range(0, 255));
        2:       d = ~WIDTH'($urandom_range(0, 255));
        default: d = WIDTH'($urandom) >> $urandom_range(0, 31);
      endcase
      issue(d, $urandom_range(0, WIDTH - 1));
    end
    rand_bp = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
